// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store, memory-side and status signals of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;

    logic                  ls_req;
    logic                  ls_we;
    logic [DATA_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [3:0]            ls_byte_slct;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_done;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_byte_slct;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic                  stall_if;
    logic                  stall_mem;
    logic                  bus_err;

    // Arbiter side
    modport master (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_byte_slct,
        input  mem_rdata, mem_ready,
        output if_rdata, if_done, ls_rdata, ls_done,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_byte_slct,
        output stall_if, stall_mem, bus_err
    );

    // Requester and memory side
    modport slave (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_byte_slct,
        output mem_rdata, mem_ready,
        input  if_rdata, if_done, ls_rdata, ls_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_byte_slct,
        input  stall_if, stall_mem, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch and load/store,
// with load/store priority bounded by a fetch-starvation streak and an access timeout.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LS_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned STREAK_W = $clog2(LS_STREAK_MAX + 1);
    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, DONE} state_t;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [3:0]            byte_slct;
    } mem_cmd_t;

    state_t                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_cmd_t              cmd_q, cmd_d;
    logic                  mem_en_q, mem_en_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  if_done_q, if_done_d;
    logic                  ls_done_q, ls_done_d;
    logic                  bus_err_q, bus_err_d;
    logic [DATA_WIDTH-1:0] rd_data;

    // Next-state, grant, access tracking and completion capture
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        mem_en_d   = mem_en_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        bus_err_d  = 1'b0;
        rd_data    = '0;

        case (state_q)
            IDLE: begin
                if (bus.if_req && (!bus.ls_req || streak_q == STREAK_W'(LS_STREAK_MAX))) begin
                    state_d         = IF_ACC;
                    streak_d        = '0;
                    cnt_d           = '0;
                    mem_en_d        = 1'b1;
                    cmd_d.we        = 1'b0;
                    cmd_d.addr      = bus.if_addr;
                    cmd_d.wdata     = '0;
                    cmd_d.byte_slct = 4'b1111;
                end else if (bus.ls_req) begin
                    state_d         = LS_ACC;
                    cnt_d           = '0;
                    mem_en_d        = 1'b1;
                    cmd_d.we        = bus.ls_we;
                    cmd_d.addr      = bus.ls_addr;
                    cmd_d.wdata     = bus.ls_wdata;
                    cmd_d.byte_slct = bus.ls_byte_slct;
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(LS_STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            IF_ACC, LS_ACC: begin
                // mem_ready wins over a timeout landing in the same cycle
                if (bus.mem_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    mem_en_d  = 1'b0;
                    cmd_d     = '0;
                    bus_err_d = !bus.mem_ready;
                    rd_data   = (bus.mem_ready && !cmd_q.we) ? bus.mem_rdata : '0;
                    if (state_q == IF_ACC) begin
                        if_rdata_d = rd_data;
                        if_done_d  = 1'b1;
                    end else begin
                        ls_rdata_d = rd_data;
                        ls_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            mem_en_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            mem_en_q   <= mem_en_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.mem_en        = mem_en_q;
    assign bus.mem_we        = cmd_q.we;
    assign bus.mem_addr      = cmd_q.addr;
    assign bus.mem_wdata     = cmd_q.wdata;
    assign bus.mem_byte_slct = cmd_q.byte_slct;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign bus.if_done       = if_done_q;
    assign bus.ls_done       = ls_done_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.stall_if      = bus.if_req & ~if_done_q;
    assign bus.stall_mem     = bus.ls_req & ~ls_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random job mix checked
// against a job-level model of the arbitration and completion rules.
module tb_mem_port_arbiter;
    localparam int unsigned DW            = 32;
    localparam int          LS_STREAK_MAX = 4;
    localparam int          TIMEOUT       = 16;

    typedef struct {
        bit          is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bs;
        int          lat;   // ACC cycles before mem_ready; >= TIMEOUT never answers
    } job_t;

    logic        clk;
    logic        rst;
    logic        ready_force;
    logic [7:0]  acc;
    logic [7:0]  lat_now;
    int          n_checks;
    int          n_err;
    int          m_streak;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_ls_rdata;
    job_t        if_q[$];
    job_t        ls_q[$];
    int          grant_log[$];
    int          exp_order[8];

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .LS_STREAK_MAX(LS_STREAK_MAX),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h2402_000A;
        return (a ^ 32'h5A5A_A5A5) + 32'h0000_1111;
    endfunction

    // Memory model: answers after lat_now cycles of an access
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_ready) acc <= acc + 8'd1;
        else                              acc <= 8'd0;
    end
    assign bus.mem_ready = ready_force | (bus.mem_en & (acc == lat_now));
    assign bus.mem_rdata = bus.mem_en ? mem_word(bus.mem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic job_t mk_if(input logic [31:0] a, input int lat);
        job_t j;
        j.is_if = 1'b1; j.we = 1'b0; j.addr = a; j.wdata = 32'h0; j.bs = 4'hF; j.lat = lat;
        return j;
    endfunction

    function automatic job_t mk_ls(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] bs, input int lat);
        job_t j;
        j.is_if = 1'b0; j.we = we; j.addr = a; j.wdata = wd; j.bs = bs; j.lat = lat;
        return j;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)  return int'($urandom_range(0, 2));
        if (r == 7) return TIMEOUT - 1;
        if (r == 8) return TIMEOUT - 2;
        return 255;
    endfunction

    // Each requester holds req and operands of its oldest job until that job completes
    task automatic drive_fronts();
        if (if_q.size() != 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = if_q[0].addr;
        end else begin
            bus.if_req  = 1'b0;
            bus.if_addr = 32'h0;
        end
        if (ls_q.size() != 0) begin
            bus.ls_req       = 1'b1;
            bus.ls_we        = ls_q[0].we;
            bus.ls_addr      = ls_q[0].addr;
            bus.ls_wdata     = ls_q[0].wdata;
            bus.ls_byte_slct = ls_q[0].bs;
        end else begin
            bus.ls_req       = 1'b0;
            bus.ls_we        = 1'b0;
            bus.ls_addr      = 32'h0;
            bus.ls_wdata     = 32'h0;
            bus.ls_byte_slct = 4'h0;
        end
    endtask

    // Runs queued jobs to completion; call just after a rising edge with the DUT idle
    task automatic run_jobs();
        int          cyc;
        int          exp_grant;
        int          done_at;
        int          guard;
        bit          win_if;
        bit          tout;
        bit          in_acc;
        bit          is_done;
        job_t        cur;
        logic [31:0] rd;
        cyc       = 0;
        exp_grant = 1;
        done_at   = -1;
        guard     = 0;
        win_if    = 1'b0;
        tout      = 1'b0;
        cur       = mk_if(32'h0, 0);
        drive_fronts();
        while ((if_q.size() != 0 || ls_q.size() != 0) && guard < 3000) begin
            @(negedge clk);
            if (cyc == exp_grant) begin
                win_if = (if_q.size() != 0) && (ls_q.size() == 0 || m_streak == LS_STREAK_MAX);
                if (win_if) begin
                    cur      = if_q[0];
                    m_streak = 0;
                end else begin
                    cur      = ls_q[0];
                    m_streak = (if_q.size() != 0) ?
                               ((m_streak < LS_STREAK_MAX) ? m_streak + 1 : m_streak) : 0;
                end
                lat_now = 8'(cur.lat);
                tout    = (cur.lat >= TIMEOUT);
                done_at = cyc + (tout ? TIMEOUT : cur.lat + 1);
            end
            in_acc  = (cyc >= exp_grant) && (cyc < done_at);
            is_done = (cyc == done_at);
            check("mem_en", 32'(bus.mem_en), 32'(in_acc));
            if (in_acc) begin
                check("mem_we", 32'(bus.mem_we), 32'(cur.we));
                check("mem_addr", bus.mem_addr, cur.addr);
                check("mem_wdata", bus.mem_wdata, cur.wdata);
                check("mem_byte_slct", 32'(bus.mem_byte_slct), 32'(cur.bs));
            end else begin
                check("mem_addr_idle", bus.mem_addr, 32'h0);
                check("mem_byte_slct_idle", 32'(bus.mem_byte_slct), 32'h0);
            end
            check("if_done", 32'(bus.if_done), 32'(is_done && win_if));
            check("ls_done", 32'(bus.ls_done), 32'(is_done && !win_if));
            check("bus_err", 32'(bus.bus_err), 32'(is_done && tout));
            check("stall_if", 32'(bus.stall_if), 32'((if_q.size() != 0) && !(is_done && win_if)));
            check("stall_mem", 32'(bus.stall_mem), 32'((ls_q.size() != 0) && !(is_done && !win_if)));
            if (is_done) begin
                grant_log.push_back(bus.if_done ? 1 : (bus.ls_done ? 0 : -1));
                rd = (tout || cur.we) ? 32'h0 : mem_word(cur.addr);
                if (win_if) begin
                    exp_if_rdata = rd;
                    void'(if_q.pop_front());
                end else begin
                    exp_ls_rdata = rd;
                    void'(ls_q.pop_front());
                end
                exp_grant = cyc + 2;
            end
            check("if_rdata", bus.if_rdata, exp_if_rdata);
            check("ls_rdata", bus.ls_rdata, exp_ls_rdata);
            @(posedge clk);
            #1;
            drive_fronts();
            cyc++;
            guard++;
        end
        if (guard >= 3000) begin
            check("run_jobs_budget", 32'(guard), 32'h0);
            if_q.delete();
            ls_q.delete();
            drive_fronts();
        end
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        m_streak     = 0;
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        lat_now      = 8'd0;
        ready_force  = 1'b0;
        rst          = 1'b0;
        exp_order    = '{0, 0, 0, 0, 1, 0, 0, 1};
        drive_fronts();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'(bus.mem_en), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'h0);
        check("rst_ls_done", 32'(bus.ls_done), 32'h0);
        check("rst_bus_err", 32'(bus.bus_err), 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_ls_rdata", bus.ls_rdata, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch, minimum latency
        if_q.push_back(mk_if(32'h0000_0100, 0));
        run_jobs();
        check("fetch_word", bus.if_rdata, 32'h2402_000A);

        // Simultaneous requests: store first, then fetch
        grant_log.delete();
        ls_q.push_back(mk_ls(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b0011, 1));
        if_q.push_back(mk_if(32'h0000_0300, 0));
        run_jobs();
        check("simul_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("simul_first_ls", 32'(grant_log[0]), 32'd0);
            check("simul_then_if", 32'(grant_log[1]), 32'd1);
        end
        check("simul_store_rdata", bus.ls_rdata, 32'h0);

        // Starvation guard: four loads/stores, then the waiting fetch
        grant_log.delete();
        for (int i = 0; i < 6; i++)
            ls_q.push_back(mk_ls(1'(i % 2), 32'h0000_0400 + 32'(i * 4), $urandom, 4'b1111, 0));
        if_q.push_back(mk_if(32'h0000_0500, 0));
        if_q.push_back(mk_if(32'h0000_0504, 1));
        run_jobs();
        check("starve_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("starve_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Timeout, then an answer in the last allowed cycle
        ls_q.push_back(mk_ls(1'b0, 32'h0000_0600, 32'h0, 4'b1111, 255));
        run_jobs();
        check("timeout_rdata", bus.ls_rdata, 32'h0);
        ls_q.push_back(mk_ls(1'b0, 32'h0000_0604, 32'h0, 4'b1111, TIMEOUT - 1));
        run_jobs();
        check("late_ready_rdata", bus.ls_rdata, mem_word(32'h0000_0604));

        // mem_ready outside an access is ignored
        ready_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_ready_en", 32'(bus.mem_en), 32'h0);
            check("stray_ready_if_done", 32'(bus.if_done), 32'h0);
            check("stray_ready_ls_done", 32'(bus.ls_done), 32'h0);
            check("stray_ready_ls_rdata", bus.ls_rdata, exp_ls_rdata);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b0;

        // Random mix of fetches and loads/stores
        for (int i = 0; i < 25; i++)
            if_q.push_back(mk_if($urandom & 32'hFFFF_FFFC, rand_lat()));
        for (int i = 0; i < 35; i++)
            ls_q.push_back(mk_ls(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                                 4'($urandom), rand_lat()));
        run_jobs();

        // Reset in the middle of a load
        lat_now          = 8'd255;
        bus.ls_req       = 1'b1;
        bus.ls_we        = 1'b0;
        bus.ls_addr      = 32'h0000_0700;
        bus.ls_wdata     = 32'h0;
        bus.ls_byte_slct = 4'hF;
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0800;
        @(negedge clk);
        check("midrst_acc_en", 32'(bus.mem_en), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("midrst_en_now", 32'(bus.mem_en), 32'h0);
        check("midrst_addr_now", bus.mem_addr, 32'h0);
        check("midrst_ls_done", 32'(bus.ls_done), 32'h0);
        check("midrst_if_rdata", bus.if_rdata, 32'h0);
        check("midrst_ls_rdata", bus.ls_rdata, 32'h0);
        bus.ls_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_en", 32'(bus.mem_en), 32'h0);
            check("midrst_hold_ls_done", 32'(bus.ls_done), 32'h0);
        end
        lat_now = 8'd0;
        rst     = 1'b1;
        @(negedge clk);
        check("postrst_grant_en", 32'(bus.mem_en), 32'h1);
        check("postrst_grant_addr", bus.mem_addr, 32'h0000_0800);
        check("postrst_grant_bs", 32'(bus.mem_byte_slct), 32'hF);
        @(negedge clk);
        check("postrst_if_done", 32'(bus.if_done), 32'h1);
        check("postrst_ls_done", 32'(bus.ls_done), 32'h0);
        check("postrst_if_rdata", bus.if_rdata, mem_word(32'h0000_0800));
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        @(negedge clk);
        check("postrst_idle_en", 32'(bus.mem_en), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
